axi_sram_slave: RTL and testbench

//  AXI3-style slave responder: the far end of the CPU-side AXI master. Serves

---
 rtl/axi_sram_slave.sv | 229 ++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// axi_sram_slave
//   AXI3-style slave responder backed by an internal word-addressed SRAM
//   (2**MEM_AW x 32b). Read and write channels run independent FSMs.
//   Byte address bits [MEM_AW+1:2] select the word. Upper bits alias and
//   the low two bits are ignored. Bursts are INCR or FIXED; WRAP is treated
//   as INCR. Burst indices wrap modulo 2**MEM_AW. When a read and a write
//   touch the same word in the same cycle, the read returns the old data.
// Ports
//   aclk, areset             clock, synchronous active-high reset
//   s_ar*                    read address channel (size/lock/cache/prot ignored)
//   s_r*                     read data channel (rresp always OKAY)
//   s_aw*                    write address channel (size/lock/cache/prot ignored)
//   s_w*                     write data channel (wid, wlast ignored)
//   s_b*                     write response channel (bresp always OKAY)
module axi_sram_slave #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 12
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ID_W-1:0]   s_arid,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic [7:0]        s_arlen,
  input  logic [2:0]        s_arsize,
  input  logic [1:0]        s_arburst,
  input  logic [1:0]        s_arlock,
  input  logic [3:0]        s_arcache,
  input  logic [2:0]        s_arprot,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [ID_W-1:0]   s_rid,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic              s_rvalid,
  input  logic              s_rready,
  input  logic [ID_W-1:0]   s_awid,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic [7:0]        s_awlen,
  input  logic [2:0]        s_awsize,
  input  logic [1:0]        s_awburst,
  input  logic [1:0]        s_awlock,
  input  logic [3:0]        s_awcache,
  input  logic [2:0]        s_awprot,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [ID_W-1:0]   s_wid,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wlast,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [ID_W-1:0]   s_bid,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready
);

  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  logic [31:0] mem [2**MEM_AW];

  // Read channel state
  rstate_t             rstate_q, rstate_d;
  logic [ID_W-1:0]     rid_q, rid_d;
  logic [MEM_AW-1:0]   ridx_q, ridx_d;
  logic [7:0]          rlen_q, rlen_d;
  logic [7:0]          rcnt_q, rcnt_d;
  logic                rfixed_q, rfixed_d;
  logic [31:0]         rdata_q;
  logic                rd_en;
  logic [MEM_AW-1:0]   rd_idx;

  // Write channel state
  wstate_t             wstate_q, wstate_d;
  logic [ID_W-1:0]     wid_q, wid_d;
  logic [MEM_AW-1:0]   widx_q, widx_d;
  logic [7:0]          wlen_q, wlen_d;
  logic [7:0]          wcnt_q, wcnt_d;
  logic                wfixed_q, wfixed_d;
  logic                mem_we;

  logic unused_ok;
  assign unused_ok = ^{s_araddr[ADDR_W-1:MEM_AW+2], s_araddr[1:0], s_arsize,
                       s_arlock, s_arcache, s_arprot,
                       s_awaddr[ADDR_W-1:MEM_AW+2], s_awaddr[1:0], s_awsize,
                       s_awlock, s_awcache, s_awprot, s_wid, s_wlast};

  // Read FSM: the SRAM read for the next beat is issued on the same edge
  // that accepts AR or completes the previous beat, so data is registered
  // one cycle later and held in rdata_q while the master stalls.
  always_comb begin
    rstate_d = rstate_q;
    rid_d    = rid_q;
    ridx_d   = ridx_q;
    rlen_d   = rlen_q;
    rcnt_d   = rcnt_q;
    rfixed_d = rfixed_q;
    rd_en    = 1'b0;
    rd_idx   = ridx_q;
    case (rstate_q)
      R_IDLE: begin
        if (s_arvalid) begin
          rstate_d = R_DATA;
          rid_d    = s_arid;
          ridx_d   = s_araddr[MEM_AW+1:2];
          rlen_d   = s_arlen;
          rcnt_d   = '0;
          rfixed_d = (s_arburst == 2'b00);
          rd_en    = 1'b1;
          rd_idx   = s_araddr[MEM_AW+1:2];
        end
      end
      R_DATA: begin
        if (s_rready) begin
          if (rcnt_q == rlen_q) begin
            rstate_d = R_IDLE;
          end else begin
            rcnt_d = rcnt_q + 8'd1;
            ridx_d = rfixed_q ? ridx_q : ridx_q + 1'b1;
            rd_en  = 1'b1;
            rd_idx = ridx_d;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Write FSM
  always_comb begin
    wstate_d = wstate_q;
    wid_d    = wid_q;
    widx_d   = widx_q;
    wlen_d   = wlen_q;
    wcnt_d   = wcnt_q;
    wfixed_d = wfixed_q;
    mem_we   = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (s_awvalid) begin
          wstate_d = W_DATA;
          wid_d    = s_awid;
          widx_d   = s_awaddr[MEM_AW+1:2];
          wlen_d   = s_awlen;
          wcnt_d   = '0;
          wfixed_d = (s_awburst == 2'b00);
        end
      end
      W_DATA: begin
        if (s_wvalid) begin
          mem_we = 1'b1;
          if (wcnt_q == wlen_q) begin
            wstate_d = W_RESP;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
            widx_d = wfixed_q ? widx_q : widx_q + 1'b1;
          end
        end
      end
      W_RESP: begin
        if (s_bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rstate_q <= R_IDLE;
      rid_q    <= '0;
      ridx_q   <= '0;
      rlen_q   <= '0;
      rcnt_q   <= '0;
      rfixed_q <= 1'b0;
      wstate_q <= W_IDLE;
      wid_q    <= '0;
      widx_q   <= '0;
      wlen_q   <= '0;
      wcnt_q   <= '0;
      wfixed_q <= 1'b0;
    end else begin
      rstate_q <= rstate_d;
      rid_q    <= rid_d;
      ridx_q   <= ridx_d;
      rlen_q   <= rlen_d;
      rcnt_q   <= rcnt_d;
      rfixed_q <= rfixed_d;
      wstate_q <= wstate_d;
      wid_q    <= wid_d;
      widx_q   <= widx_d;
      wlen_q   <= wlen_d;
      wcnt_q   <= wcnt_d;
      wfixed_q <= wfixed_d;
    end
  end

  // SRAM array: never reset, byte-enabled writes.
  always_ff @(posedge aclk) begin
    if (mem_we && !areset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (s_wstrb[i]) mem[widx_q][8*i +: 8] <= s_wdata[8*i +: 8];
      end
    end
  end

  // Read register samples the array before this edge's write lands,
  // giving read-before-write on a same-word collision.
  always_ff @(posedge aclk) begin
    if (areset)     rdata_q <= '0;
    else if (rd_en) rdata_q <= mem[rd_idx];
  end

  // Outputs forced to zero during reset and whenever not valid.
  assign s_arready = !areset && (rstate_q == R_IDLE);
  assign s_rvalid  = !areset && (rstate_q == R_DATA);
  assign s_rid     = s_rvalid ? rid_q : '0;
  assign s_rdata   = s_rvalid ? rdata_q : '0;
  assign s_rlast   = s_rvalid && (rcnt_q == rlen_q);
  assign s_rresp   = 2'b00;
  assign s_awready = !areset && (wstate_q == W_IDLE);
  assign s_wready  = !areset && (wstate_q == W_DATA);
  assign s_bvalid  = !areset && (wstate_q == W_RESP);
  assign s_bid     = s_bvalid ? wid_q : '0;
  assign s_bresp   = 2'b00;

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;
  localparam int ID_W = 4, ADDR_W = 32, MEM_AW = 12, WORDS = 4096;

  logic aclk = 1'b0, areset;
  logic [ID_W-1:0] s_arid, s_rid, s_awid, s_wid, s_bid;
  logic [ADDR_W-1:0] s_araddr, s_awaddr;
  logic [7:0] s_arlen, s_awlen;
  logic [2:0] s_arsize, s_awsize, s_arprot, s_awprot;
  logic [1:0] s_arburst, s_awburst, s_arlock, s_awlock, s_rresp, s_bresp;
  logic [3:0] s_arcache, s_awcache, s_wstrb;
  logic s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] s_rdata, s_wdata;

  axi_sram_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .MEM_AW(MEM_AW)) dut (
    .aclk(aclk), .areset(areset),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache), .s_awprot(s_awprot),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  always #5 aclk = ~aclk;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake not seen within cycle budget (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  bit [31:0] mm [int];          // word index -> contents; absent = never fully written

  bit        m_rbusy;           // a read burst is being returned
  logic [3:0] m_rid;
  int        m_ridx, m_rleft;   // current word, beats still to deliver
  bit        m_rfix;
  logic [31:0] m_rexp;
  bit        m_rknown;

  bit        m_wdata_phase, m_wresp_phase;
  logic [3:0] m_wid;
  int        m_widx, m_wleft;
  bit        m_wfix;

  function automatic int word_of(input logic [31:0] a);
    return int'(a[13:2]);
  endfunction

  function automatic void fetch(input int idx);
    m_rknown = mm.exists(idx);
    m_rexp   = m_rknown ? mm[idx] : 32'h0;
  endfunction

  function automatic void store(input int idx, input logic [31:0] d, input logic [3:0] strb);
    logic [31:0] w;
    if (mm.exists(idx)) begin
      w = mm[idx];
      for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = d[8*b +: 8];
      mm[idx] = w;
    end else if (strb == 4'hF) begin
      mm[idx] = d;
    end
  endfunction

  // captured traffic for directed checks
  logic [31:0] cap_d[$];
  bit          cap_l[$];
  logic [3:0]  cap_id[$];
  logic [3:0]  cap_bid[$];
  logic [1:0]  cap_bresp[$];
  int ncyc = 0, ar_n = 0, rv_n = 0;
  bit rv_pending = 0;

  always @(negedge aclk) begin
    ncyc++;
    if (areset) begin
      chk("reset_ctrl_outs", 32'({s_arready, s_rvalid, s_rlast, s_rid, s_rresp,
                                  s_awready, s_wready, s_bvalid, s_bid, s_bresp}), 32'h0);
      chk("reset_rdata", s_rdata, 32'h0);
      m_rbusy = 0; m_wdata_phase = 0; m_wresp_phase = 0; rv_pending = 0;
    end else begin
      chk("arready", 32'(s_arready), 32'(!m_rbusy));
      chk("rvalid", 32'(s_rvalid), 32'(m_rbusy));
      chk("rlast", 32'(s_rlast), 32'(m_rbusy && m_rleft == 1));
      chk("rresp", 32'(s_rresp), 32'h0);
      if (m_rbusy) begin
        chk("rid", 32'(s_rid), 32'(m_rid));
        if (m_rknown) chk("rdata", s_rdata, m_rexp);
      end
      chk("awready", 32'(s_awready), 32'(!m_wdata_phase && !m_wresp_phase));
      chk("wready", 32'(s_wready), 32'(m_wdata_phase));
      chk("bvalid", 32'(s_bvalid), 32'(m_wresp_phase));
      if (m_wresp_phase) begin
        chk("bid", 32'(s_bid), 32'(m_wid));
        chk("bresp", 32'(s_bresp), 32'h0);
      end

      if (s_rvalid && rv_pending) begin rv_n = ncyc; rv_pending = 0; end
      if (s_rvalid && s_rready) begin
        cap_d.push_back(s_rdata); cap_l.push_back(s_rlast); cap_id.push_back(s_rid);
      end
      if (s_bvalid && s_bready) begin
        cap_bid.push_back(s_bid); cap_bresp.push_back(s_bresp);
      end

      // effect of the coming edge; reads see memory before this edge's write
      if (!m_rbusy && s_arvalid) begin
        m_rbusy = 1; m_rid = s_arid; m_ridx = word_of(s_araddr);
        m_rleft = int'(s_arlen) + 1; m_rfix = (s_arburst == 2'b00);
        fetch(m_ridx);
        ar_n = ncyc; rv_pending = 1;
      end else if (m_rbusy && s_rready) begin
        m_rleft--;
        if (m_rleft == 0) m_rbusy = 0;
        else begin
          if (!m_rfix) m_ridx = (m_ridx + 1) % WORDS;
          fetch(m_ridx);
        end
      end

      if (m_wresp_phase) begin
        if (s_bready) m_wresp_phase = 0;
      end else if (m_wdata_phase) begin
        if (s_wvalid) begin
          store(m_widx, s_wdata, s_wstrb);
          m_wleft--;
          if (m_wleft == 0) begin m_wdata_phase = 0; m_wresp_phase = 1; end
          else if (!m_wfix) m_widx = (m_widx + 1) % WORDS;
        end
      end else if (s_awvalid) begin
        m_wdata_phase = 1; m_wid = s_awid; m_widx = word_of(s_awaddr);
        m_wleft = int'(s_awlen) + 1; m_wfix = (s_awburst == 2'b00);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] wbuf_d [16];
  logic [3:0]  wbuf_s [16];

  task automatic next_cycle;
    @(posedge aclk); #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input int len,
                          input logic [1:0] burst, input int gapmax);
    int n;
    s_awaddr = addr; s_awid = id; s_awlen = 8'(len); s_awburst = burst;
    s_awsize = 3'd2; s_awvalid = 1;
    n = 0;
    @(negedge aclk);
    while (!s_awready && n < 200) begin n++; @(negedge aclk); end
    if (!s_awready) timeout("aw_handshake");
    next_cycle();
    s_awvalid = 0;
    for (int b = 0; b <= len; b++) begin
      repeat ($urandom_range(0, gapmax)) next_cycle();
      s_wdata = wbuf_d[b]; s_wstrb = wbuf_s[b]; s_wid = id; s_wlast = (b == len);
      s_wvalid = 1;
      n = 0;
      @(negedge aclk);
      while (!s_wready && n < 200) begin n++; @(negedge aclk); end
      if (!s_wready) timeout("w_handshake");
      next_cycle();
      s_wvalid = 0;
    end
    repeat ($urandom_range(0, gapmax)) next_cycle();
    s_bready = 1;
    n = 0;
    @(negedge aclk);
    while (!s_bvalid && n < 200) begin n++; @(negedge aclk); end
    if (!s_bvalid) timeout("b_handshake");
    next_cycle();
    s_bready = 0;
  endtask

  // mode 0: rready high, 1: toggling, 2: random
  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input int len,
                         input logic [1:0] burst, input int mode);
    int n, beats;
    bit t;
    s_araddr = addr; s_arid = id; s_arlen = 8'(len); s_arburst = burst;
    s_arsize = 3'd2; s_arvalid = 1;
    n = 0;
    @(negedge aclk);
    while (!s_arready && n < 200) begin n++; @(negedge aclk); end
    if (!s_arready) timeout("ar_handshake");
    next_cycle();
    s_arvalid = 0;
    beats = 0; n = 0; t = 0;
    while (beats <= len && n < 400) begin
      case (mode)
        0: s_rready = 1;
        1: begin s_rready = t; t = !t; end
        default: s_rready = 1'($urandom_range(0, 1));
      endcase
      @(negedge aclk);
      if (s_rvalid && s_rready) beats++;
      next_cycle();
      n++;
    end
    if (beats <= len) timeout("r_beats");
    s_rready = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    int idx;
    idx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 31)) : int'($urandom_range(4064, 4095));
    return ($urandom() & 32'hFFFF_C000) | 32'(idx << 2) | ($urandom() & 32'h3);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    areset = 1;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = 3'd2; s_arburst = 2'b01;
    s_arlock = 2'b01; s_arcache = 4'h3; s_arprot = 3'h2; s_arvalid = 0; s_rready = 0;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = 3'd2; s_awburst = 2'b01;
    s_awlock = 2'b01; s_awcache = 4'h3; s_awprot = 3'h2; s_awvalid = 0;
    s_wid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = 0; s_wvalid = 0; s_bready = 0;
    repeat (3) next_cycle();
    areset = 0;

    // preload the two random-traffic windows (indices 0..63 and 4032..4095)
    for (int blk = 0; blk < 8; blk++) begin
      for (int b = 0; b < 16; b++) begin wbuf_d[b] = $urandom(); wbuf_s[b] = 4'hF; end
      do_write(32'((blk < 4 ? blk * 16 : 4032 + (blk - 4) * 16) << 2), 4'(blk), 15, 2'b01, 0);
    end

    // 1: single write/read, IDs echoed
    cap_bid.delete(); cap_bresp.delete(); cap_d.delete(); cap_l.delete(); cap_id.delete();
    wbuf_d[0] = 32'hDEADBEEF; wbuf_s[0] = 4'hF;
    do_write(32'h1000, 4'h3, 0, 2'b01, 1);
    chk("t1_bcount", cap_bid.size(), 1);
    chk("t1_bid", 32'(cap_bid[0]), 32'h3);
    chk("t1_bresp", 32'(cap_bresp[0]), 32'h0);
    do_read(32'h1000, 4'h5, 0, 2'b01, 0);
    chk("t1_rcount", cap_d.size(), 1);
    chk("t1_rdata", cap_d[0], 32'hDEADBEEF);
    chk("t1_rlast", 32'(cap_l[0]), 32'h1);
    chk("t1_rid", 32'(cap_id[0]), 32'h5);

    // 2: byte strobes
    wbuf_d[0] = 32'h11223344; wbuf_s[0] = 4'hF;
    do_write(32'h1004, 4'h1, 0, 2'b01, 0);
    wbuf_d[0] = 32'hAABBCCDD; wbuf_s[0] = 4'b0010;
    do_write(32'h1004, 4'h1, 0, 2'b01, 0);
    cap_d.delete(); cap_l.delete(); cap_id.delete();
    do_read(32'h1004, 4'h2, 0, 2'b01, 0);
    chk("t2_rdata", cap_d[0], 32'h1122CC44);

    // 3: INCR burst with stalls
    for (int b = 0; b < 4; b++) begin wbuf_d[b] = 32'(b + 1); wbuf_s[b] = 4'hF; end
    do_write(32'h2000, 4'h7, 3, 2'b01, 2);
    cap_d.delete(); cap_l.delete(); cap_id.delete();
    do_read(32'h2000, 4'h9, 3, 2'b01, 1);
    chk("t3_rcount", cap_d.size(), 4);
    for (int b = 0; b < 4; b++) begin
      chk("t3_rdata", cap_d[b], 32'(b + 1));
      chk("t3_rlast", 32'(cap_l[b]), 32'(b == 3));
    end

    // 4: FIXED burst, AR->rvalid latency
    cap_d.delete(); cap_l.delete(); cap_id.delete();
    do_read(32'h1000, 4'hA, 2, 2'b00, 0);
    chk("t4_rcount", cap_d.size(), 3);
    for (int b = 0; b < 3; b++) begin
      chk("t4_rdata", cap_d[b], 32'hDEADBEEF);
      chk("t4_rlast", 32'(cap_l[b]), 32'(b == 2));
    end
    chk("t4_latency", 32'(rv_n - ar_n), 32'd1);

    // 5: same-cycle read and write of one word
    wbuf_d[0] = 32'h0; wbuf_s[0] = 4'hF;
    do_write(32'h3000, 4'h0, 0, 2'b01, 0);
    s_awaddr = 32'h3000; s_awid = 4'h4; s_awlen = 0; s_awburst = 2'b01; s_awvalid = 1;
    next_cycle();
    s_awvalid = 0;
    cap_d.delete(); cap_l.delete(); cap_id.delete(); cap_bid.delete();
    s_wdata = 32'h55; s_wstrb = 4'hF; s_wvalid = 1; s_wlast = 1;
    s_araddr = 32'h3000; s_arid = 4'h6; s_arlen = 0; s_arburst = 2'b01; s_arvalid = 1;
    s_rready = 1; s_bready = 1;
    @(negedge aclk);
    chk("t5_both_ready", 32'({s_wready, s_arready}), 32'h3);
    next_cycle();
    s_wvalid = 0; s_arvalid = 0;
    n = 0;
    while ((cap_d.size() == 0 || cap_bid.size() == 0) && n < 50) begin next_cycle(); n++; end
    if (n >= 50) timeout("t5_completion");
    s_rready = 0; s_bready = 0;
    chk("t5_old_data", cap_d[0], 32'h0);
    cap_d.delete(); cap_l.delete(); cap_id.delete();
    do_read(32'h3000, 4'h6, 0, 2'b01, 0);
    chk("t5_new_data", cap_d[0], 32'h55);

    // 6: reset in the middle of a read burst
    cap_d.delete(); cap_l.delete(); cap_id.delete();
    s_araddr = 32'h2000; s_arid = 4'h8; s_arlen = 3; s_arburst = 2'b01; s_arvalid = 1;
    s_rready = 1;
    next_cycle();
    s_arvalid = 0;
    n = 0;
    while (cap_d.size() < 2 && n < 50) begin @(negedge aclk); n++; end
    if (cap_d.size() < 2) timeout("t6_two_beats");
    next_cycle();
    areset = 1;
    @(negedge aclk);
    chk("t6_rvalid_in_reset", 32'(s_rvalid), 32'h0);
    next_cycle();
    areset = 0; s_rready = 0;
    @(negedge aclk);
    chk("t6_arready_after", 32'(s_arready), 32'h1);
    chk("t6_rvalid_after", 32'(s_rvalid), 32'h0);
    next_cycle();
    cap_d.delete(); cap_l.delete(); cap_id.delete();
    do_read(32'h2000, 4'h8, 0, 2'b01, 0);
    chk("t6_sram_kept", cap_d[0], 32'h1);

    // random concurrent traffic, aliased addresses, wrap at top of memory
    fork
      begin
        for (int t = 0; t < 40; t++) begin
          int len;
          len = int'($urandom_range(0, 15));
          for (int b = 0; b <= len; b++) begin
            wbuf_d[b] = $urandom();
            wbuf_s[b] = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'hF;
          end
          do_write(rand_addr(), 4'($urandom()), len, 2'($urandom_range(0, 2)), 2);
        end
      end
      begin
        for (int t = 0; t < 40; t++) begin
          do_read(rand_addr(), 4'($urandom()), int'($urandom_range(0, 15)),
                  2'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
          repeat ($urandom_range(0, 3)) next_cycle();
        end
      end
    join

    repeat (4) next_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
